// File: rtl/vectorgates_pkg.sv
// rtl/vectorgates_pkg.sv - shared constants and types for the vector-gate operand loader
package vectorgates_pkg;

  localparam int OPERAND_W  = 3;
  localparam int FRAME_BITS = 7;
  localparam int IDX_W      = $clog2(FRAME_BITS);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/vectorgates_pair_fifo.sv
// rtl/vectorgates_pair_fifo.sv - small circular FIFO of operand pairs
module vectorgates_pair_fifo
  import vectorgates_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  operand_pair_t push_data_i,
  input  logic          pop_i,
  output operand_pair_t head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CNT_W-1:0] count_o
);

  operand_pair_t       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    rd_ptr_d = do_pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_next(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer, occupancy and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/vectorgates_operand_loader.sv
// rtl/vectorgates_operand_loader.sv - serial frame deserialiser with parity check and operand FIFO
module vectorgates_operand_loader
  import vectorgates_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sin_valid,
  input  logic                 sin_start,
  input  logic                 sin_data,
  output logic [OPERAND_W-1:0] a,
  output logic [OPERAND_W-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 par_err,
  output logic                 ovf,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  par_err_q, par_err_d;
  logic                  ovf_q, ovf_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic                  bit_start, bit_shift, last_bit, abort;
  logic                  parity_bad, pop, push, push_ok, err_evt;
  logic [FRAME_BITS-1:0] frame_w;
  operand_pair_t         push_data, head;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  // Bit classification: a start bit always opens a frame, other bits only count in SHIFT.
  always_comb begin
    bit_start  = sin_valid && sin_start;
    bit_shift  = sin_valid && !sin_start && (state_q == SHIFT);
    last_bit   = bit_shift && (idx_q == IDX_W'(FRAME_BITS - 1));
    abort      = bit_start && (state_q == SHIFT);
    frame_w    = {sin_data, shreg_q[FRAME_BITS-2:0]};
    parity_bad = ^frame_w;
    pop        = out_valid && out_ready;
    push_ok    = !fifo_full || pop;
    push       = last_bit && !parity_bad && push_ok;
    push_data.a = frame_w[OPERAND_W-1:0];
    push_data.b = frame_w[2*OPERAND_W-1:OPERAND_W];
    par_err_d  = last_bit && parity_bad;
    ovf_d      = last_bit && !parity_bad && !push_ok;
    err_evt    = abort || par_err_d || ovf_d;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: an abort restarts inside SHIFT, the seventh bit returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bit_start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy reflects the registered state only.
  always_comb begin
    busy = (state_q == SHIFT);
  end

  // Shift register and bit index; the index holds through stall cycles.
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (bit_start) begin
      shreg_d    = '0;
      shreg_d[0] = sin_data;
      idx_d      = IDX_W'(1);
    end else if (bit_shift) begin
      shreg_d[idx_q] = sin_data;
      idx_d          = last_bit ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Error counter saturates at all-ones; at most one event can occur per cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Datapath and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      shreg_q   <= '0;
      par_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      par_err_q <= par_err_d;
      ovf_q     <= ovf_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  vectorgates_pair_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Head is forced to zero while the FIFO is empty so downstream never sees stale data.
  always_comb begin
    out_valid = (fifo_count != '0);
    a         = out_valid ? head.a : '0;
    b         = out_valid ? head.b : '0;
    par_err   = par_err_q;
    ovf       = ovf_q;
    err_cnt   = err_cnt_q;
  end

  // Occupancy and empty flag must always agree.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (fifo_empty == (fifo_count == '0));
    end
  end

endmodule
